// File: rtl/lcm_pkg.sv
// Shared definitions for the sequential LCM unit: controller states and
// result/step-counter width helpers.
package lcm_pkg;

   localparam int unsigned W_DEFAULT = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Result width: the LCM of two W-bit operands fits in 2*W bits.
   function automatic int unsigned rw(input int unsigned w);
      return 2 * w;
   endfunction

   // Step-counter width: at most A+B-2 additions, which fits in W+1 bits.
   function automatic int unsigned sw(input int unsigned w);
      return w + 1;
   endfunction

endpackage

// File: rtl/lcm_datapath.sv
// Operand and running-multiple registers, the 2W-bit adders and the comparator
// of the LCM unit; sequenced entirely by strobes from lcm_seq.
module lcm_datapath
   import lcm_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 add_a,
   input  logic                 add_b,
   input  logic                 latch_out,
   input  logic [W-1:0]         in_a,
   input  logic [W-1:0]         in_b,
   output logic                 lt,
   output logic                 gt,
   output logic                 eq,
   output logic [rw(W)-1:0]     vout,
   output logic [sw(W)-1:0]     steps
);

   localparam int unsigned RW = rw(W);
   localparam int unsigned SW = sw(W);

   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [RW-1:0] ma_q, ma_d;
   logic [RW-1:0] mb_q, mb_d;
   logic [RW-1:0] vout_q, vout_d;
   logic [SW-1:0] steps_q, steps_d;

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      vout_d  = vout_q;
      steps_d = steps_q;
      // Loading clears vout, so a zero operand reaches DONE with vout=0.
      if (load) begin
         a_d     = in_a;
         b_d     = in_b;
         ma_d    = RW'(in_a);
         mb_d    = RW'(in_b);
         vout_d  = '0;
         steps_d = '0;
      end else begin
         if (add_a) begin
            ma_d    = ma_q + RW'(a_q);
            steps_d = steps_q + SW'(1);
         end
         if (add_b) begin
            mb_d    = mb_q + RW'(b_q);
            steps_d = steps_q + SW'(1);
         end
         if (latch_out) begin
            vout_d = ma_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         vout_q  <= '0;
         steps_q <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         vout_q  <= vout_d;
         steps_q <= steps_d;
      end
   end

   assign lt    = (ma_q < mb_q);
   assign gt    = (ma_q > mb_q);
   assign eq    = (ma_q == mb_q);
   assign vout  = vout_q;
   assign steps = steps_q;

endmodule

// File: rtl/lcm_seq.sv
// Sequential LCM unit: grows two running multiples until they meet, with
// valid/ready handshakes on operand input and result output.
module lcm_seq
   import lcm_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     inA,
   input  logic [W-1:0]     inB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   vout,
   output logic [W:0]       steps
);

   state_t state_q, state_d;
   logic   load, add_a, add_b, latch_out;
   logic   lt, gt, eq;

   lcm_datapath #(.W(W)) u_dp (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .add_a     (add_a),
      .add_b     (add_b),
      .latch_out (latch_out),
      .in_a      (inA),
      .in_b      (inB),
      .lt        (lt),
      .gt        (gt),
      .eq        (eq),
      .vout      (vout),
      .steps     (steps)
   );

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      add_a     = 1'b0;
      add_b     = 1'b0;
      latch_out = 1'b0;
      // Handshake outputs are masked during reset so nothing is offered or
      // accepted while a job is being abandoned.
      in_ready  = (state_q == S_IDLE) && !rst;
      out_valid = (state_q == S_DONE) && !rst;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               load    = 1'b1;
               state_d = ((inA == '0) || (inB == '0)) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (eq) begin
               latch_out = 1'b1;
               state_d   = S_DONE;
            end else if (lt) begin
               add_a = 1'b1;
            end else if (gt) begin
               add_b = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule
